ps2_tone_scheduler: RTL

//  Sits between PS2_Controller and Audio_Controller.

---
 rtl/ps2_tone_scheduler.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_tone_scheduler.sv
// PS/2 game-key decoder with last-pressed tone arbitration, square-wave generator
// and sample-rate handshake into the audio output FIFO.
module ps2_tone_scheduler #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SAMPLE_DIV = 1042,
  parameter int FREQ_UP    = 440,
  parameter int FREQ_DOWN  = 490,
  parameter int FREQ_LEFT  = 624,
  parameter int FREQ_RIGHT = 580,
  parameter int FREQ_SPACE = 669,
  parameter int AMPLITUDE  = 100_000_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  received_data,
  input  logic        received_data_en,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic [4:0]  key_held,
  output logic [2:0]  active_key,
  output logic [7:0]  overrun_cnt
);

  localparam logic [31:0] HALF_UP    = 32'(CLK_HZ / (32'sd2 * FREQ_UP));
  localparam logic [31:0] HALF_DOWN  = 32'(CLK_HZ / (32'sd2 * FREQ_DOWN));
  localparam logic [31:0] HALF_LEFT  = 32'(CLK_HZ / (32'sd2 * FREQ_LEFT));
  localparam logic [31:0] HALF_RIGHT = 32'(CLK_HZ / (32'sd2 * FREQ_RIGHT));
  localparam logic [31:0] HALF_SPACE = 32'(CLK_HZ / (32'sd2 * FREQ_SPACE));
  localparam logic [31:0] DIV_LAST   = 32'(SAMPLE_DIV - 32'sd1);
  localparam logic [31:0] AMP        = 32'(AMPLITUDE);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  function automatic logic [2:0] key_code(input logic [7:0] b);
    case (b)
      8'h75:   return 3'd1;
      8'h72:   return 3'd2;
      8'h6B:   return 3'd3;
      8'h74:   return 3'd4;
      8'h29:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [4:0] key_mask(input logic [2:0] k);
    case (k)
      3'd1:    return 5'b00001;
      3'd2:    return 5'b00010;
      3'd3:    return 5'b00100;
      3'd4:    return 5'b01000;
      3'd5:    return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [2:0] prio_key(input logic [4:0] h);
    if (h[0])      return 3'd1;
    else if (h[1]) return 3'd2;
    else if (h[2]) return 3'd3;
    else if (h[3]) return 3'd4;
    else if (h[4]) return 3'd5;
    else           return 3'd0;
  endfunction

  function automatic logic [31:0] half_of(input logic [2:0] k);
    case (k)
      3'd1:    return HALF_UP;
      3'd2:    return HALF_DOWN;
      3'd3:    return HALF_LEFT;
      3'd4:    return HALF_RIGHT;
      3'd5:    return HALF_SPACE;
      default: return 32'd1;
    endcase
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_next_s;
  logic        is_make_s;
  logic        is_break_s;
  logic [2:0]  code_s;
  logic [4:0]  mask_s;
  logic [2:0]  make_evt_r;
  logic [2:0]  active_next_s;
  logic [31:0] phase_r;
  logic        pol_r;
  logic [31:0] half_s;
  logic [31:0] sample_s;
  logic [31:0] div_r;
  logic        strobe_s;
  logic        issue_s;
  logic        pending_r;
  logic [31:0] hold_r;
  logic        hold_valid_r;
  logic [31:0] sample_out_r;

  assign code_s   = key_code(received_data);
  assign mask_s   = key_mask(code_s);
  assign half_s   = half_of(active_key);
  assign sample_s = (active_key == 3'd0) ? 32'd0 : (pol_r ? AMP : (32'd0 - AMP));
  assign strobe_s = (div_r == DIV_LAST);
  assign issue_s  = pending_r & audio_out_allowed & ~write_audio_out;

  assign left_channel_audio_out  = sample_out_r;
  assign right_channel_audio_out = sample_out_r;

  // Parser next-state and make/break classification of the incoming byte.
  always_comb begin
    state_next_s = state_r;
    is_make_s    = 1'b0;
    is_break_s   = 1'b0;
    if (received_data_en) begin
      case (state_r)
        ST_IDLE: begin
          if (received_data == BYTE_EXT) begin
            state_next_s = ST_EXT;
          end else if (received_data == BYTE_BRK) begin
            state_next_s = ST_BRK;
          end else begin
            is_make_s = 1'b1;
          end
        end
        ST_EXT: begin
          if (received_data == BYTE_BRK) begin
            state_next_s = ST_EXT_BRK;
          end else begin
            is_make_s    = 1'b1;
            state_next_s = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          if ((received_data == BYTE_EXT) || (received_data == BYTE_BRK)) begin
            state_next_s = state_r;
          end else begin
            is_break_s   = 1'b1;
            state_next_s = ST_IDLE;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Parser state and held-key flags; a make of a not-yet-held key is remembered for arbitration.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      key_held   <= 5'd0;
      make_evt_r <= 3'd0;
    end else begin
      state_r    <= state_next_s;
      make_evt_r <= 3'd0;
      if (is_make_s) begin
        key_held <= key_held | mask_s;
        if ((mask_s & ~key_held) != 5'd0) begin
          make_evt_r <= code_s;
        end
      end else if (is_break_s) begin
        key_held <= key_held & ~mask_s;
      end
    end
  end

  // Last-pressed wins; losing the active key falls back to fixed priority.
  always_comb begin
    active_next_s = active_key;
    if (make_evt_r != 3'd0) begin
      active_next_s = make_evt_r;
    end else if ((active_key != 3'd0) && ((key_mask(active_key) & key_held) == 5'd0)) begin
      active_next_s = prio_key(key_held);
    end else begin
      active_next_s = active_key;
    end
  end

  // Active key register and square-wave phase; any change of key restarts at positive polarity.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      active_key <= 3'd0;
      phase_r    <= 32'd0;
      pol_r      <= 1'b0;
    end else begin
      active_key <= active_next_s;
      if (active_next_s != active_key) begin
        phase_r <= 32'd0;
        pol_r   <= 1'b1;
      end else if (active_key == 3'd0) begin
        phase_r <= 32'd0;
      end else if (phase_r == (half_s - 32'd1)) begin
        phase_r <= 32'd0;
        pol_r   <= ~pol_r;
      end else begin
        phase_r <= phase_r + 32'd1;
      end
    end
  end

  // Sample strobe, FIFO write handshake and overrun counting. A strobe landing on the
  // write-issue edge parks the new sample in hold_r so the outgoing one stays on the bus.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_r           <= 32'd0;
      pending_r       <= 1'b0;
      hold_r          <= 32'd0;
      hold_valid_r    <= 1'b0;
      sample_out_r    <= 32'd0;
      write_audio_out <= 1'b0;
      overrun_cnt     <= 8'd0;
    end else begin
      div_r           <= strobe_s ? 32'd0 : (div_r + 32'd1);
      write_audio_out <= issue_s;
      if (strobe_s) begin
        pending_r <= 1'b1;
        if (issue_s) begin
          hold_r       <= sample_s;
          hold_valid_r <= 1'b1;
        end else begin
          sample_out_r <= sample_s;
          hold_valid_r <= 1'b0;
          if (pending_r && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
          end
        end
      end else begin
        if (issue_s) begin
          pending_r <= 1'b0;
        end
        if (hold_valid_r) begin
          sample_out_r <= hold_r;
          hold_valid_r <= 1'b0;
        end
      end
    end
  end

endmodule
